// File: rtl/vending_mealy_param.sv
// Parameterised coin vending controller: accumulates credit, vends at PRICE_UNITS and pays change as chg5 pulses.
// Optional refund input 'cancel' is present only when VEND_CANCEL_EN is defined.
module vending_mealy_param #(
  parameter int PRICE_UNITS = 4,
  parameter int CRED_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        coin,
`ifdef VEND_CANCEL_EN
  input  logic              cancel,
`endif
  output logic              dispense,
  output logic              chg5,
  output logic              busy,
  output logic              coin_rej,
  output logic [CRED_W-1:0] credit
);

  // Worst-case sum is (PRICE_UNITS-1) credit plus a 5-unit coin.
  if (PRICE_UNITS < 1) begin : g_bad_price
    $error("vending_mealy_param: PRICE_UNITS must be >= 1");
  end
  if ((PRICE_UNITS + 4) > ((2 ** CRED_W) - 1)) begin : g_bad_width
    $error("vending_mealy_param: CRED_W too narrow to hold PRICE_UNITS+4");
  end

  localparam logic [CRED_W-1:0] PRICE = CRED_W'(PRICE_UNITS);

  typedef enum logic {
    COLLECT = 1'b0,
    CHANGE  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic [CRED_W-1:0] cnt_q, cnt_d;
  logic              dispense_q, dispense_d;
  logic              chg5_q, chg5_d;
  logic              busy_q, busy_d;
  logic              rej_q, rej_d;

  logic [CRED_W-1:0] coin_val;
  logic [CRED_W-1:0] sum;
  logic [CRED_W-1:0] change_k;
  logic              refund_req;

`ifdef VEND_CANCEL_EN
  assign refund_req = cancel;
`else
  assign refund_req = 1'b0;
`endif

  always_comb begin
    coin_val = '0;
    case (coin)
      2'b01:   coin_val = CRED_W'(1);
      2'b10:   coin_val = CRED_W'(2);
      2'b11:   coin_val = CRED_W'(5);
      default: coin_val = '0;
    endcase
  end

  assign sum      = credit_q + coin_val;
  assign change_k = sum - PRICE;

  // cnt_q holds the pulses still owed after the one currently on chg5.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    cnt_d      = cnt_q;
    dispense_d = 1'b0;
    chg5_d     = 1'b0;
    busy_d     = 1'b0;
    rej_d      = 1'b0;
    case (state_q)
      COLLECT: begin
        if (refund_req) begin
          credit_d = '0;
          if (sum != '0) begin
            state_d = CHANGE;
            cnt_d   = sum - CRED_W'(1);
            chg5_d  = 1'b1;
            busy_d  = 1'b1;
          end
        end else if (coin != 2'b00) begin
          if (sum >= PRICE) begin
            dispense_d = 1'b1;
            credit_d   = '0;
            if (change_k != '0) begin
              state_d = CHANGE;
              cnt_d   = change_k - CRED_W'(1);
              chg5_d  = 1'b1;
              busy_d  = 1'b1;
            end else begin
              cnt_d = '0;
            end
          end else begin
            credit_d = sum;
          end
        end
      end
      CHANGE: begin
        rej_d = (coin != 2'b00);
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - CRED_W'(1);
          chg5_d = 1'b1;
          busy_d = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      credit_q   <= '0;
      cnt_q      <= '0;
      dispense_q <= 1'b0;
      chg5_q     <= 1'b0;
      busy_q     <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      cnt_q      <= cnt_d;
      dispense_q <= dispense_d;
      chg5_q     <= chg5_d;
      busy_q     <= busy_d;
      rej_q      <= rej_d;
    end
  end

  assign dispense = dispense_q;
  assign chg5     = chg5_q;
  assign busy     = busy_q;
  assign coin_rej = rej_q;
  assign credit   = credit_q;

endmodule
